// File: rtl/mccoy_pkg.sv
`default_nettype none
// ============================================================================
// mccoy_pkg : shared McCoy core types (fetch states, pc_sel encoding, widths)
// Rev 1.0
// ============================================================================
package mccoy_pkg;

  localparam int DEFAULT_ADDR_W  = 8;
  localparam int DEFAULT_INSTR_W = 8;

  // pc_sel encoding, shared with the branch unit that drives it
  localparam logic PCSEL_SEQ  = 1'b1;
  localparam logic PCSEL_LOAD = 1'b0;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
// pc_fetch_if : instruction-memory req/ack fetch bus
// Rev 1.0
// ============================================================================
interface pc_fetch_if
  import mccoy_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int INSTR_W = DEFAULT_INSTR_W
);

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);

endinterface
`default_nettype wire

// File: rtl/pc_fetch_pc_next.sv
`default_nettype none
// ============================================================================
// pc_next : combinational next-PC select (sequential increment or load target)
// Rev 1.0
// ============================================================================
module pc_next
  import mccoy_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  wire logic [ADDR_W-1:0] pc,
  input  wire logic              pc_sel,
  input  wire logic [ADDR_W-1:0] target,
  output logic      [ADDR_W-1:0] next_pc
);

  // Increment wraps naturally at 2^ADDR_W
  always_comb begin
    next_pc = target;
    case (pc_sel)
      PCSEL_SEQ:  next_pc = pc + ADDR_W'(1);
      PCSEL_LOAD: next_pc = target;
      default:    next_pc = target;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// pc_fetch : McCoy program counter and single-outstanding instruction fetch
// Rev 1.0
// ============================================================================
module pc_fetch
  import mccoy_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               pc_sel,
  input  wire logic [ADDR_W-1:0]  target,
  input  wire logic               advance,
  pc_fetch_if.master              imem,
  output logic                    instr_valid,
  output logic      [INSTR_W-1:0] instr,
  output logic      [ADDR_W-1:0]  pc,
  output logic      [7:0]         retired
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [7:0]         retired_q, retired_d;
  logic [ADDR_W-1:0]  next_pc;

  pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc      (pc_q),
    .pc_sel  (pc_sel),
    .target  (target),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        // An ack only counts against a request already on the bus
        if (req_q && imem.ack) begin
          instr_d = imem.data;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_EXEC;
        end else begin
          req_d   = 1'b1;
        end
      end
      S_EXEC: begin
        if (advance) begin
          pc_d      = next_pc;
          retired_d = retired_q + 8'd1;
          valid_d   = 1'b0;
          req_d     = 1'b1;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem.req    = req_q;
  assign imem.addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch : randomized transaction-level check of pc_fetch
// Rev 1.0
// ============================================================================
module tb_pc_fetch;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       pc_sel  = 1'b1;
  logic [7:0] target  = 8'h00;
  logic       advance = 1'b0;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] pc;
  logic [7:0] retired;

  pc_fetch_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  pc_fetch #(
    .ADDR_W   (8),
    .INSTR_W  (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_sel      (pc_sel),
    .target      (target),
    .advance     (advance),
    .imem        (bus),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mem [256];
  logic [7:0] exp_pc;
  logic [7:0] exp_retired;
  logic [7:0] exp_instr;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic noise();
    pc_sel = 1'($urandom_range(0, 1));
    target = 8'($urandom_range(0, 255));
  endtask

  task automatic check_state(input string tag, input logic exp_req, input logic exp_valid);
    check({tag, ".req"},     8'(bus.req),     8'(exp_req));
    check({tag, ".addr"},    bus.addr,        exp_pc);
    check({tag, ".pc"},      pc,              exp_pc);
    check({tag, ".valid"},   8'(instr_valid), 8'(exp_valid));
    check({tag, ".instr"},   instr,           exp_instr);
    check({tag, ".retired"}, retired,         exp_retired);
  endtask

  // One reset cycle, then release (optionally with a stale ack on release)
  task automatic do_reset(input logic adv, input logic late_ack);
    reset    = 1'b1;
    bus.ack  = 1'b0;
    advance  = adv;
    pc_sel   = 1'b1;
    step();
    exp_pc      = 8'h00;
    exp_retired = 8'h00;
    exp_instr   = 8'h00;
    check_state("rst", 1'b0, 1'b0);
    reset    = 1'b0;
    advance  = 1'b0;
    bus.ack  = late_ack;
    bus.data = 8'h5A;
    step();
    bus.ack  = 1'b0;
    check_state("rel", 1'b1, 1'b0);
  endtask

  task automatic do_fetch(input int waits, input logic adv_noise);
    for (int w = 0; w < waits; w++) begin
      bus.ack  = 1'b0;
      bus.data = 8'($urandom_range(0, 255));
      advance  = adv_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      noise();
      step();
      check_state("wait", 1'b1, 1'b0);
    end
    bus.ack  = 1'b1;
    bus.data = mem[exp_pc];
    advance  = adv_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    noise();
    step();
    bus.ack  = 1'b0;
    bus.data = 8'($urandom_range(0, 255));
    advance  = 1'b0;
    exp_instr = mem[exp_pc];
    check_state("fetch", 1'b0, 1'b1);
  endtask

  task automatic do_exec(input int idle, input logic sel, input logic [7:0] tgt);
    for (int i = 0; i < idle; i++) begin
      advance = 1'b0;
      bus.ack = 1'($urandom_range(0, 1));
      noise();
      step();
      check_state("exec", 1'b0, 1'b1);
    end
    bus.ack = 1'b0;
    advance = 1'b1;
    pc_sel  = sel;
    target  = tgt;
    step();
    advance = 1'b0;
    noise();
    exp_pc      = sel ? exp_pc + 8'd1 : tgt;
    exp_retired = exp_retired + 8'd1;
    check_state("adv", 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_ff;
    seen_ff = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0]   = 8'hA1;
    bus.ack  = 1'b0;
    bus.data = 8'h00;
    step();

    // Reset release with a spurious ack, then zero-wait fetch of 0xA1
    do_reset(1'b0, 1'b1);
    do_fetch(0, 1'b0);
    check("first_instr", instr, 8'hA1);

    // Sequential increment from 0x05 and wrap from 0xFF
    do_exec(2, 1'b0, 8'h05);
    do_fetch(1, 1'b0);
    do_exec(0, 1'b1, 8'h77);
    check("inc_pc", pc, 8'h06);
    do_fetch(0, 1'b0);
    do_exec(0, 1'b0, 8'hFF);
    do_fetch(0, 1'b0);
    do_exec(1, 1'b1, 8'h12);
    check("wrap_pc", pc, 8'h00);

    // Jump with target noise in idle cycles, then 3 wait states
    do_fetch(0, 1'b0);
    do_exec(4, 1'b0, 8'h3C);
    check("jump_pc", bus.addr, 8'h3C);
    do_fetch(3, 1'b1);

    // Reset mid-fetch with an ack arriving the cycle after reset
    do_exec(0, 1'b1, 8'h00);
    bus.ack = 1'b0;
    step();
    check_state("midfetch", 1'b1, 1'b0);
    do_reset(1'b0, 1'b1);
    do_fetch(0, 1'b0);

    // Reset beats advance in S_EXEC
    do_exec(0, 1'b1, 8'h00);
    do_fetch(2, 1'b0);
    do_reset(1'b1, 1'b0);
    check("rst_exec_ret", retired, 8'h00);

    // Random traffic across a full retirement-counter wrap
    for (int n = 0; n < 300; n++) begin
      do_fetch(int'($urandom_range(0, 3)), 1'b1);
      do_exec(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)));
      if (exp_retired == 8'hFF) seen_ff = 1'b1;
    end
    check("ret_final", retired, 8'(300 % 256));
    check("saw_ff", 8'(seen_ff), 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
